palm_locator: RTL and testbench
===============================

# palm_locator

Streaming palm bounding-box extractor. It consumes the binary segmented pixel stream, one pixel per cycle in raster order over a 120x160 frame, and finds the tallest contiguous band of "wide" rows, which is taken as the palm. It publishes that band's bounding box once per frame as the `palm_*` geometry consumed by the finger-identification stage. A `palm_width` of 0 means no palm was found.

## Interface
- `IMAGE_WIDTH`, 120, pixels per row (columns 0..119).
- `IMAGE_HEIGHT`, 160, rows per frame (rows 0..159).
- `PALM_ROW_MIN`, 20, minimum white pixels in a row for it to count as a palm row.
- `PALM_MIN_ROWS`, 8, minimum band height for a valid palm.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `object_image`  in  1  segmented pixel; 1 = object (white).
- `pixel_valid`  in  1  `object_image` is sampled only when high.
- `sof`  in  1  start of frame; qualified by `pixel_valid`; marks pixel (0,0).
- `palm_width`  out  8  `end_of_palm_c - start_of_palm_c + 1`, or 0.
- `palm_height`  out  8  `end_of_palm_r - start_of_palm_r + 1`, or 0.
- `start_of_palm_r`, `end_of_palm_r`  out  8  first and last row of the band.
- `start_of_palm_c`, `end_of_palm_c`  out  8  minimum and maximum white column over the band's rows.
- `frame_done`  out  1  one-cycle pulse; all geometry outputs update on the same edge.

## Operation
- **Reset** (`rst`=0, asynchronous): all outputs are 0. State is IDLE. All counters and statistics are cleared.
- **States:** IDLE, SCAN, FINAL.
- **IDLE:** waits for `pixel_valid`&`sof`. That pixel is accepted as (0,0) and the state goes to SCAN. Valid pixels without `sof` are ignored.
- **SCAN:** each valid pixel advances the column counter. At column `IMAGE_WIDTH-1` the column wraps to 0 and the row increments. Invalid cycles change nothing.
- **Per-row statistics:**
  - `row_white` (8 bit) counts white pixels in the row.
  - `row_min_c` and `row_max_c` track the first and last white column in the row.
  - All three are cleared at each row start.
- **Row close** (when the row's last pixel is accepted): the accepted pixel is included in the statistics. The row is a palm row if `row_white` >= `PALM_ROW_MIN`.
  - **Palm row:** if no run is open, open one with `run_start` = row, `run_len` = 1, and the column limits taken from the row. Otherwise increment `run_len` and fold in min/max of the columns.
  - **Non-palm row:** close any open run. It replaces the best run only if `run_len` > `best_len` (strictly greater, so the earlier run wins a tie).
- **Frame end:** the last pixel (row `IMAGE_HEIGHT-1`, column `IMAGE_WIDTH-1`) closes its row, then the state goes to FINAL.
- **FINAL** (one cycle):
  - Any still-open run is compared against best using the same strict rule.
  - If `best_len` >= `PALM_MIN_ROWS`, publish the best run's geometry.
  - Otherwise all six geometry outputs are 0.
  - Pulse `frame_done`, then return to IDLE.
  - `pixel_valid` and `sof` are ignored in FINAL. Upstream guarantees at least one cycle of blanking between frames.
- **`sof` during SCAN:** the partial frame is discarded. The statistics restart with this pixel as (0,0). Outputs are unchanged and there is no `frame_done`.
- **Output hold:** outputs hold their last published values until the next `frame_done` or reset.
- **Width rules:**
  - All counters are 8-bit unsigned. The maximum values are 119 for columns, 159 for rows and 120 for `row_white`, so none can overflow.
  - `run_len` saturates implicitly at 160.
  - `palm_width` and `palm_height` are computed from registered band limits, so no subtraction can underflow (end >= start always).

## Timing
- Latency: with the last frame pixel accepted at edge N, `frame_done` and the new geometry are registered at edge N+1. `frame_done` is high for exactly one cycle.
- Throughput: one pixel per cycle, with no backpressure. `pixel_valid` gaps of any length are tolerated.
- A complete frame with no gaps takes 19200 accepted cycles plus 1 cycle in FINAL.
- Reset asserted mid-frame clears outputs immediately, without waiting for a clock edge. After release the block waits in IDLE for `sof`.

## Test plan
1. **All-zero frame**, contiguous valid → `frame_done` one cycle after pixel (159,119); all six outputs are 0.
2. **White rectangle** rows 40..79, columns 30..69 → `start_of_palm_r`=40, `end_of_palm_r`=79, `start_of_palm_c`=30, `end_of_palm_c`=69, `palm_width`=40, `palm_height`=40.
3. **Competing runs:**
   - Band A rows 10..19 (cols 0..49) and band B rows 60..89 (cols 20..59) → band B is published (rows 60..89, width 40, height 30).
   - Repeat with two equal 15-row bands → the first band is published.
4. **Thresholds:**
   - Rectangle 19 columns wide → all outputs 0.
   - 7-row band of width 50 → all outputs 0.
   - 8-row band of width 20 → published with height 8.
5. **Frame-end closure:** rectangle rows 150..159, cols 100..119 → `end_of_palm_r`=159, `end_of_palm_c`=119, height 10, width 20.
6. **Robustness:**
   - Random `pixel_valid` gaps during test 2 → identical result.
   - `sof` re-asserted at row 70 → no `frame_done` for the aborted frame; the restarted frame reports correctly.
   - `rst` low at row 50 → outputs 0 with no clock edge needed; the next full frame reports correctly.

Source files
------------

// File: rtl/palm_locator.sv
// Streaming palm bounding-box extractor.
// Finds the tallest contiguous band of rows that each hold at least PALM_ROW_MIN white pixels
// and publishes its bounding box once per frame; an all-zero result means no palm was found.
module palm_locator #(
  parameter int unsigned IMAGE_WIDTH   = 120,
  parameter int unsigned IMAGE_HEIGHT  = 160,
  parameter int unsigned PALM_ROW_MIN  = 20,
  parameter int unsigned PALM_MIN_ROWS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       object_image,
  input  logic       pixel_valid,
  input  logic       sof,
  output logic [7:0] palm_width,
  output logic [7:0] palm_height,
  output logic [7:0] start_of_palm_r,
  output logic [7:0] end_of_palm_r,
  output logic [7:0] start_of_palm_c,
  output logic [7:0] end_of_palm_c,
  output logic       frame_done
);

  localparam logic [7:0] LastCol = 8'(IMAGE_WIDTH - 1);
  localparam logic [7:0] LastRow = 8'(IMAGE_HEIGHT - 1);
  localparam logic [7:0] RowMin  = 8'(PALM_ROW_MIN);
  localparam logic [7:0] MinRows = 8'(PALM_MIN_ROWS);

  typedef enum logic [1:0] {StIdle, StScan, StFinal} state_e;

  state_e     state_q, state_d;
  logic [7:0] col_q, col_d, row_q, row_d;
  logic [7:0] row_white_q, row_white_d, row_min_q, row_min_d, row_max_q, row_max_d;
  logic       run_open_q, run_open_d;
  logic [7:0] run_start_q, run_start_d, run_len_q, run_len_d;
  logic [7:0] run_min_q, run_min_d, run_max_q, run_max_d;
  logic [7:0] best_start_q, best_start_d, best_len_q, best_len_d;
  logic [7:0] best_min_q, best_min_d, best_max_q, best_max_d;
  logic [7:0] width_q, width_d, height_q, height_d;
  logic [7:0] sr_q, sr_d, er_q, er_d, sc_q, sc_d, ec_q, ec_d;
  logic       done_q, done_d;

  // Scratch signals for the pixel currently being accepted.
  logic       accept;
  logic [7:0] pc, pr, white_base;
  logic [7:0] fin_start, fin_len, fin_min, fin_max;

  // Next-state: pixel accounting, row close, run/best tracking and final publish.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    row_white_d  = row_white_q;
    row_min_d    = row_min_q;
    row_max_d    = row_max_q;
    run_open_d   = run_open_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    best_min_d   = best_min_q;
    best_max_d   = best_max_q;
    width_d      = width_q;
    height_d     = height_q;
    sr_d         = sr_q;
    er_d         = er_q;
    sc_d         = sc_q;
    ec_d         = ec_q;
    done_d       = 1'b0;
    accept       = 1'b0;
    pc           = col_q;
    pr           = row_q;
    white_base   = 8'd0;
    fin_start    = best_start_q;
    fin_len      = best_len_q;
    fin_min      = best_min_q;
    fin_max      = best_max_q;

    case (state_q)
      StIdle:  accept = pixel_valid & sof;
      StScan:  accept = pixel_valid;
      default: accept = 1'b0;
    endcase

    // sof (from IDLE or mid-frame) restarts the frame at (0,0) and drops all run history.
    if (accept && sof) begin
      pc         = 8'd0;
      pr         = 8'd0;
      run_open_d = 1'b0;
      best_len_d = 8'd0;
    end

    if (accept) begin
      // Column 0 starts a fresh row, so the previous row's statistics are ignored.
      white_base  = (pc == 8'd0) ? 8'd0 : row_white_q;
      row_white_d = white_base + {7'd0, object_image};
      row_min_d   = (object_image && white_base == 8'd0) ? pc :
                    ((pc == 8'd0) ? 8'd0 : row_min_q);
      row_max_d   = object_image ? pc : ((pc == 8'd0) ? 8'd0 : row_max_q);
      state_d     = StScan;

      if (pc == LastCol) begin
        col_d = 8'd0;
        row_d = pr + 8'd1;
        if (row_white_d >= RowMin) begin
          if (run_open_d) begin
            run_len_d = run_len_d + 8'd1;
            if (row_min_d < run_min_d) run_min_d = row_min_d;
            if (row_max_d > run_max_d) run_max_d = row_max_d;
          end else begin
            run_open_d  = 1'b1;
            run_start_d = pr;
            run_len_d   = 8'd1;
            run_min_d   = row_min_d;
            run_max_d   = row_max_d;
          end
        end else begin
          // Strictly greater: on a tie the earlier band is kept.
          if (run_open_d && run_len_d > best_len_d) begin
            best_start_d = run_start_d;
            best_len_d   = run_len_d;
            best_min_d   = run_min_d;
            best_max_d   = run_max_d;
          end
          run_open_d = 1'b0;
        end
        if (pr == LastRow) state_d = StFinal;
      end else begin
        col_d = pc + 8'd1;
        row_d = pr;
      end
    end

    if (state_q == StFinal) begin
      // A band touching the bottom edge is still open here and competes like any other.
      if (run_open_q && run_len_q > best_len_q) begin
        fin_start = run_start_q;
        fin_len   = run_len_q;
        fin_min   = run_min_q;
        fin_max   = run_max_q;
      end
      if (fin_len >= MinRows) begin
        sr_d     = fin_start;
        er_d     = fin_start + fin_len - 8'd1;
        sc_d     = fin_min;
        ec_d     = fin_max;
        height_d = fin_len;
        width_d  = fin_max - fin_min + 8'd1;
      end else begin
        sr_d     = 8'd0;
        er_d     = 8'd0;
        sc_d     = 8'd0;
        ec_d     = 8'd0;
        height_d = 8'd0;
        width_d  = 8'd0;
      end
      run_open_d = 1'b0;
      done_d     = 1'b1;
      state_d    = StIdle;
    end
  end

  // State and statistics registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      row_white_q  <= '0;
      row_min_q    <= '0;
      row_max_q    <= '0;
      run_open_q   <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      run_min_q    <= '0;
      run_max_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      best_min_q   <= '0;
      best_max_q   <= '0;
      width_q      <= '0;
      height_q     <= '0;
      sr_q         <= '0;
      er_q         <= '0;
      sc_q         <= '0;
      ec_q         <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_white_q  <= row_white_d;
      row_min_q    <= row_min_d;
      row_max_q    <= row_max_d;
      run_open_q   <= run_open_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      best_min_q   <= best_min_d;
      best_max_q   <= best_max_d;
      width_q      <= width_d;
      height_q     <= height_d;
      sr_q         <= sr_d;
      er_q         <= er_d;
      sc_q         <= sc_d;
      ec_q         <= ec_d;
      done_q       <= done_d;
    end
  end

  assign palm_width      = width_q;
  assign palm_height     = height_q;
  assign start_of_palm_r = sr_q;
  assign end_of_palm_r   = er_q;
  assign start_of_palm_c = sc_q;
  assign end_of_palm_c   = ec_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_palm_locator.sv
// Self-checking bench for palm_locator on a reduced 64x40 frame.
module tb_palm_locator;

  localparam int W = 64;
  localparam int H = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic object_image = 1'b0;
  logic pixel_valid = 1'b0;
  logic sof = 1'b0;
  logic [7:0] palm_width, palm_height, start_of_palm_r, end_of_palm_r;
  logic [7:0] start_of_palm_c, end_of_palm_c;
  logic frame_done;

  int checks = 0;
  int errors = 0;
  int done_cnt;
  logic last_done;
  bit img[H][W];
  logic [47:0] exp_geom;
  logic [47:0] prev_geom;
  wire [47:0] geom = {palm_width, palm_height, start_of_palm_r, end_of_palm_r,
                      start_of_palm_c, end_of_palm_c};

  palm_locator #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PALM_ROW_MIN(20), .PALM_MIN_ROWS(8)
  ) dut (
    .clk(clk), .rst(rst), .object_image(object_image), .pixel_valid(pixel_valid), .sof(sof),
    .palm_width(palm_width), .palm_height(palm_height),
    .start_of_palm_r(start_of_palm_r), .end_of_palm_r(end_of_palm_r),
    .start_of_palm_c(start_of_palm_c), .end_of_palm_c(end_of_palm_c),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic clear_img();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 1'b0;
  endtask

  task automatic add_rect(input int r0, input int r1, input int c0, input int c1);
    for (int r = r0; r <= r1; r++) for (int c = c0; c <= c1; c++) img[r][c] = 1'b1;
  endtask

  // Reference: scan the stored image row by row, keep the longest qualifying band.
  task automatic model();
    int best_len, best_start, best_min, best_max;
    int run_len, run_start, run_min, run_max;
    int cnt, mn, mx;
    best_len = 0; best_start = 0; best_min = 0; best_max = 0;
    run_len = 0; run_start = 0; run_min = 0; run_max = 0;
    for (int r = 0; r <= H; r++) begin
      cnt = 0; mn = W; mx = -1;
      if (r < H) begin
        for (int c = 0; c < W; c++) begin
          if (img[r][c]) begin
            cnt++;
            if (c < mn) mn = c;
            if (c > mx) mx = c;
          end
        end
      end
      if (r < H && cnt >= 20) begin
        if (run_len == 0) begin
          run_start = r; run_min = mn; run_max = mx;
        end else begin
          if (mn < run_min) run_min = mn;
          if (mx > run_max) run_max = mx;
        end
        run_len++;
      end else begin
        if (run_len > best_len) begin
          best_len = run_len; best_start = run_start; best_min = run_min; best_max = run_max;
        end
        run_len = 0;
      end
    end
    if (best_len >= 8)
      exp_geom = {8'(best_max - best_min + 1), 8'(best_len), 8'(best_start),
                  8'(best_start + best_len - 1), 8'(best_min), 8'(best_max)};
    else
      exp_geom = '0;
  endtask

  task automatic drive_pixel(input logic v, input logic s, input logic p);
    @(negedge clk);
    last_done = frame_done;
    if (frame_done) done_cnt++;
    pixel_valid = v;
    sof = s;
    object_image = p;
  endtask

  task automatic drive_rows(input int n, input int gap);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < W; c++) begin
        while (int'($urandom_range(0, 99)) < gap)
          drive_pixel(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive_pixel(1'b1, (r == 0 && c == 0), img[r][c]);
      end
    end
  endtask

  // Drives the stored image as one full frame and checks timing and geometry against the model.
  task automatic test_frame(input string name, input int gap);
    logic [2:0] tail;
    model();
    done_cnt = 0;
    drive_rows(H, gap);
    for (int i = 2; i >= 0; i--) begin
      drive_pixel(1'b0, 1'b0, 1'b0);
      tail[i] = last_done;
    end
    checks++;
    if (tail !== 3'b010) begin
      errors++;
      $display("FAIL %s latency: frame_done after last pixel got %b, expected 010", name, tail);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s pulses: got %0d frame_done pulses, expected 1", name, done_cnt);
    end
    checks++;
    if (geom !== exp_geom) begin
      errors++;
      $display("FAIL %s geometry: got w/h/sr/er/sc/ec %h, expected %h", name, geom, exp_geom);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (geom !== 48'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got geom %h done %b, expected 0 0", geom, frame_done);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_all_zero();
    clear_img();
    test_frame("all_zero", 0);
  endtask

  task automatic test_rect();
    clear_img();
    add_rect(10, 29, 15, 54);
    test_frame("rect", 0);
    checks++;
    if (geom !== {8'd40, 8'd20, 8'd10, 8'd29, 8'd15, 8'd54}) begin
      errors++;
      $display("FAIL rect_known: got %h, expected w40 h20 r10..29 c15..54", geom);
    end
  endtask

  task automatic test_gaps();
    clear_img();
    add_rect(10, 29, 15, 54);
    test_frame("gaps", 30);
    checks++;
    if (geom !== {8'd40, 8'd20, 8'd10, 8'd29, 8'd15, 8'd54}) begin
      errors++;
      $display("FAIL gaps_known: got %h, expected w40 h20 r10..29 c15..54", geom);
    end
  endtask

  task automatic test_competing();
    clear_img();
    add_rect(2, 11, 0, 49);
    add_rect(15, 34, 20, 59);
    test_frame("competing", 0);
    checks++;
    if (geom !== {8'd40, 8'd20, 8'd15, 8'd34, 8'd20, 8'd59}) begin
      errors++;
      $display("FAIL competing_known: got %h, expected taller band r15..34", geom);
    end
  endtask

  task automatic test_tie();
    clear_img();
    add_rect(2, 11, 0, 29);
    add_rect(20, 29, 10, 49);
    test_frame("tie", 0);
    checks++;
    if (geom !== {8'd30, 8'd10, 8'd2, 8'd11, 8'd0, 8'd29}) begin
      errors++;
      $display("FAIL tie_known: got %h, expected first band r2..11", geom);
    end
  endtask

  task automatic test_thresholds();
    clear_img();
    add_rect(5, 30, 10, 28);
    test_frame("narrow19", 0);
    clear_img();
    add_rect(10, 16, 5, 54);
    test_frame("short7", 0);
    clear_img();
    add_rect(10, 17, 30, 49);
    test_frame("min8x20", 0);
    checks++;
    if (geom !== {8'd20, 8'd8, 8'd10, 8'd17, 8'd30, 8'd49}) begin
      errors++;
      $display("FAIL min8x20_known: got %h, expected w20 h8 r10..17 c30..49", geom);
    end
  endtask

  task automatic test_frame_end();
    clear_img();
    add_rect(30, 39, 44, 63);
    test_frame("frame_end", 0);
    checks++;
    if (geom !== {8'd20, 8'd10, 8'd30, 8'd39, 8'd44, 8'd63}) begin
      errors++;
      $display("FAIL frame_end_known: got %h, expected w20 h10 r30..39 c44..63", geom);
    end
  endtask

  task automatic test_sof_restart();
    prev_geom = geom;
    clear_img();
    add_rect(2, 19, 0, 49);
    done_cnt = 0;
    drive_rows(20, 10);
    checks++;
    if (done_cnt !== 0 || geom !== prev_geom) begin
      errors++;
      $display("FAIL sof_abort: got %0d pulses geom %h, expected 0 pulses geom %h",
               done_cnt, geom, prev_geom);
    end
    clear_img();
    add_rect(5, 12, 0, 29);
    test_frame("sof_restart", 0);
  endtask

  task automatic test_reset_midframe();
    clear_img();
    add_rect(0, 39, 0, 39);
    done_cnt = 0;
    drive_rows(25, 0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (geom !== 48'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got geom %h done %b, expected 0 0", geom, frame_done);
    end
    pixel_valid = 1'b0;
    sof = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_img();
    add_rect(3, 14, 7, 40);
    test_frame("after_reset", 0);
  endtask

  task automatic test_random(input int n);
    int nr, r0, r1, c0, c1;
    for (int k = 0; k < n; k++) begin
      clear_img();
      nr = int'($urandom_range(1, 3));
      for (int i = 0; i < nr; i++) begin
        r0 = int'($urandom_range(0, H - 1));
        r1 = r0 + int'($urandom_range(0, 15));
        if (r1 > H - 1) r1 = H - 1;
        c0 = int'($urandom_range(0, W - 1));
        c1 = c0 + int'($urandom_range(10, 45));
        if (c1 > W - 1) c1 = W - 1;
        add_rect(r0, r1, c0, c1);
      end
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          if ($urandom_range(0, 99) < 3) img[r][c] = 1'b1;
      test_frame($sformatf("random%0d", k), int'($urandom_range(0, 20)));
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_rect();
    test_gaps();
    test_competing();
    test_tie();
    test_thresholds();
    test_frame_end();
    test_sof_restart();
    test_reset_midframe();
    test_random(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
